// File: rtl/fault_rec_pkg.sv
// Shared types for the fault event recorder: record layout, source ids, FSM states
// and the fixed fault-vector range boundaries.
package fault_rec_pkg;

   localparam int TS_W = 32;

   // First global bit index of each source block in the concatenated fault vector.
   localparam logic [6:0] DEC_LO  = 7'd0;
   localparam logic [6:0] CTRL_LO = 7'd72;
   localparam logic [6:0] RF_LO   = 7'd116;
   localparam logic [6:0] ALU_LO  = 7'd119;
   localparam logic [6:0] MULT_LO = 7'd122;

   typedef enum logic [2:0] {
      SRC_DEC  = 3'd0,
      SRC_CTRL = 3'd1,
      SRC_RF   = 3'd2,
      SRC_ALU  = 3'd3,
      SRC_MULT = 3'd4
   } fault_src_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_FROZEN = 2'd2
   } rec_state_e;

   typedef struct packed {
      logic [6:0]      bit_idx;
      fault_src_e      src;
      logic [TS_W-1:0] ts;
   } fault_evt_t;

   function automatic fault_src_e bit_to_src(input logic [6:0] b);
      fault_src_e s;
      if (b >= MULT_LO)      s = SRC_MULT;
      else if (b >= ALU_LO)  s = SRC_ALU;
      else if (b >= RF_LO)   s = SRC_RF;
      else if (b >= CTRL_LO) s = SRC_CTRL;
      else                   s = SRC_DEC;
      return s;
   endfunction

endpackage

// File: rtl/fault_event_recorder_if.sv
// Event drain port of the fault event recorder: the record at the FIFO head
// plus its valid/ready handshake.
interface fault_event_recorder_if;
   // Valid/ready: a record transfers on each rising clock edge where
   // evt_valid_o && evt_ready_i. While evt_valid_o is high and evt_ready_i is
   // low, the producer keeps evt_valid_o high and all record fields unchanged;
   // evt_valid_o never depends on evt_ready_i.
   logic                          evt_valid_o;
   logic                          evt_ready_i;
   logic [6:0]                    evt_bit_o;
   logic [2:0]                    evt_src_o;
   logic [fault_rec_pkg::TS_W-1:0] evt_time_o;

   modport master (
      output evt_valid_o, evt_bit_o, evt_src_o, evt_time_o,
      input  evt_ready_i
   );

   modport slave (
      input  evt_valid_o, evt_bit_o, evt_src_o, evt_time_o,
      output evt_ready_i
   );
endinterface

// File: rtl/fault_rec_fifo.sv
// Synchronous FIFO of event records; push and pop may occur in the same cycle,
// including a push into a full FIFO that is being popped.
module fault_rec_fifo
   import fault_rec_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  fault_evt_t din_i,
   input  logic       pop_i,
   output fault_evt_t dout_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW = $clog2(DEPTH);

   fault_evt_t    mem_q [DEPTH];
   fault_evt_t    mem_d [DEPTH];
   logic [AW:0]   wr_q, wr_d;
   logic [AW:0]   rd_q, rd_d;
   logic          do_push;
   logic          do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   always_comb begin
      do_pop  = pop_i && !empty_o;
      do_push = push_i && (!full_o || do_pop);
      wr_d    = wr_q;
      rd_d    = rd_q;
      mem_d   = mem_q;
      if (do_push) begin
         mem_d[wr_q[AW-1:0]] = din_i;
         wr_d                = wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fault_event_recorder.sv
// Rising-edge fault recorder: detects edges on the fault vector and queues
// timestamped records. Define FAULT_REC_STICKY_EN to record each bit only once.
module fault_event_recorder
   import fault_rec_pkg::*;
#(
   parameter int FAULT_W = 126,
   parameter int DEPTH   = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   enable_i,
   input  logic                   stop_i,
   input  logic [FAULT_W-1:0]     fault_i,
   fault_event_recorder_if.master evt,
   output logic                   pending_o,
   output logic                   overflow_o,
   output logic [15:0]            drop_cnt_o,
   output logic                   frozen_o,
   output rec_state_e             state_o
);

   rec_state_e         state_q, state_d;
   logic [FAULT_W-1:0] prev_q, prev_d;
   logic [FAULT_W-1:0] pending_q, pending_d;
   logic [TS_W-1:0]    ts_q, ts_d;
   logic [15:0]        drop_q, drop_d;
   logic               overflow_q, overflow_d;

   logic               capture;
   logic [FAULT_W-1:0] new_edges;
   logic [FAULT_W-1:0] push_mask;
   logic [FAULT_W-1:0] drop_bits;
   logic [6:0]         push_idx;
   logic [7:0]         drop_n;
   logic [16:0]        drop_sum;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   fault_evt_t         push_rec;
   fault_evt_t         head;

`ifdef FAULT_REC_STICKY_EN
   logic [FAULT_W-1:0] seen_q, seen_d;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (enable_i) state_d = ST_ARMED;
         ST_ARMED: begin
            if (stop_i)         state_d = ST_FROZEN;
            else if (!enable_i) state_d = ST_IDLE;
         end
         ST_FROZEN: state_d = ST_FROZEN;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      capture  = (state_q == ST_ARMED);
      frozen_o = (state_q == ST_FROZEN);
      state_o  = state_q;
   end

   // ---------------- edge detection, push selection, drop counting ----------------
   always_comb begin
      push_idx = '0;
      for (int i = FAULT_W - 1; i >= 0; i--) begin
         if (pending_q[i]) push_idx = 7'(i);
      end
      pop       = !fifo_empty && evt.evt_ready_i;
      push      = (|pending_q) && (!fifo_full || pop);
      push_mask = '0;
      if (push) push_mask[push_idx] = 1'b1;

      new_edges = capture ? (fault_i & ~prev_q) : '0;
`ifdef FAULT_REC_STICKY_EN
      new_edges = new_edges & ~seen_q & ~push_mask;
      seen_d    = seen_q | push_mask;
`endif

      // A bit re-edging while it is being pushed stays pending and is not a loss.
      pending_d = (pending_q & ~push_mask) | new_edges;
      drop_bits = new_edges & pending_q & ~push_mask;
      drop_n    = '0;
      for (int i = 0; i < FAULT_W; i++) begin
         drop_n = drop_n + {7'd0, drop_bits[i]};
      end
      drop_sum   = {1'b0, drop_q} + {9'd0, drop_n};
      drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      overflow_d = overflow_q || (drop_d != 16'd0);

      prev_d = fault_i;
      ts_d   = capture ? ts_q + 1'b1 : ts_q;

      push_rec.bit_idx = push_idx;
      push_rec.src     = bit_to_src(push_idx);
      push_rec.ts      = ts_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q     <= '0;
         pending_q  <= '0;
         ts_q       <= '0;
         drop_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         pending_q  <= pending_d;
         ts_q       <= ts_d;
         drop_q     <= drop_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef FAULT_REC_STICKY_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) seen_q <= '0;
      else       seen_q <= seen_d;
   end
`endif

   fault_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .din_i   (push_rec),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Head fields are forced to zero while empty so reset clears every output.
   assign evt.evt_valid_o = !fifo_empty;
   assign evt.evt_bit_o   = fifo_empty ? 7'd0 : head.bit_idx;
   assign evt.evt_src_o   = fifo_empty ? 3'd0 : head.src;
   assign evt.evt_time_o  = fifo_empty ? '0 : head.ts;

   assign pending_o  = |pending_q;
   assign overflow_o = overflow_q;
   assign drop_cnt_o = drop_q;

endmodule

// File: doc/fault_event_recorder.md
Name: fault_event_recorder

Overview:
- Sits directly downstream of the core testbench subsystem and consumes the core's concatenated fault-flag outputs: decoder[71:0], controller[43:0], regfile[2:0], alu[2:0], mult[3:0], 126 bits in total.
- Detects rising edges on every fault bit and serialises them into a FIFO of timestamped event records.
- The bench drains the FIFO through a valid/ready port for fault-injection coverage and latency analysis.

Parameters:
- FAULT_W, 126: width of the concatenated fault vector; bit 0 = decoder[0], bit 125 = mult[3].
- DEPTH, 16: event FIFO depth; power of two, >= 2.
- TS_W, 32: timestamp counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  arms recording; the timestamp counts only while high.
- stop_i  in  1  end of test (tests_passed or tests_failed); freezes recording.
- fault_i  in  FAULT_W  concatenated fault flags, {mult, alu, regfile, controller, decoder}.
- evt_valid_o  out  1  FIFO head record valid.
- evt_ready_i  in  1  consumer accepts the head record.
- evt_bit_o  out  7  global bit index of the head record.
- evt_src_o  out  3  source id: 0=DEC, 1=CTRL, 2=RF, 3=ALU, 4=MULT.
- evt_time_o  out  TS_W  timestamp at which the record was pushed.
- pending_o  out  1  edges captured but not yet pushed.
- overflow_o  out  1  sticky; set on any lost event.
- drop_cnt_o  out  16  number of lost events; saturates at 16'hFFFF.
- frozen_o  out  1  FSM is in FROZEN.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; prev-fault, pending and timestamp registers cleared.
- Assertion of rst_i mid-operation discards all FIFO contents immediately.
- FSM states:
  - IDLE: no capture. enable_i=1 moves to ARMED next cycle.
  - ARMED: capture active; timestamp increments by 1 each cycle and wraps modulo 2^TS_W. enable_i=0 returns to IDLE and keeps pending and FIFO contents. stop_i=1 moves to FROZEN.
  - FROZEN: no new captures; the timestamp holds; pushing of already-pending bits continues; draining continues. Left only by reset.
  - stop_i takes priority over enable_i=0 when both occur in the same cycle.
- Edge detection:
  - prev register is updated every cycle in all states.
  - new = fault_i & ~prev, qualified by state == ARMED.
  - pending is updated as pending | new. Each new bit whose pending bit is already set counts as one drop.
- Push:
  - Each cycle, the lowest-index pending bit is encoded; if the FIFO is not full it is pushed and cleared from pending.
  - At most one push per cycle, so an edge is detected at cycle t and pushed at t+1 at the earliest.
  - FIFO full: no push; the pending bit stays set (no loss unless it re-edges).
  - A bit that re-edges in the same cycle it is pushed is kept pending: set takes priority over clear, and no drop is counted.
- Record format: evt_time is the timestamp value in the push cycle. evt_src comes from fixed range boundaries 72, 116, 119, 122.
- Pop: occurs when evt_valid_o && evt_ready_i.
  - Simultaneous push and pop on a full FIFO is allowed.
  - Head outputs are registered from FIFO storage and remain stable while valid && !ready.
- drop_cnt_o increments by the number of drops in the cycle (popcount) and saturates. overflow_o is set when drop_cnt_o first becomes nonzero.
- pending_o = |pending.

Optional Feature:
- FAULT_REC_STICKY_EN defined: a per-bit "seen" mask is set when a bit is pushed. Later edges on a seen bit are ignored and count neither as pending nor as a drop; the mask is cleared only by reset.
- Undefined: every rising edge is recorded as specified above.

Decomposition:
- Package fault_rec_pkg:
  - fault_evt_t struct {bit[6:0], src[2:0], time[TS_W-1:0]}.
  - Source-id enum.
  - Range boundary constants DEC_LO=0, CTRL_LO=72, RF_LO=116, ALU_LO=119, MULT_LO=122.
  - FSM state enum.
  - Function bit_to_src().
- Sub-module fault_rec_fifo: synchronous FIFO, DEPTH entries of fault_evt_t, full/empty flags, push and pop allowed in the same cycle.

Test Plan:
- Single edge: enable at t=0, fault_i[5] rises at t=10 → one record with bit=5, src=DEC, time=11; evt_valid_o stays high until ready.
- Simultaneous edges: bits 120, 3 and 80 rise in one cycle → records pop in order 3 (DEC), 80 (CTRL), 120 (ALU) with consecutive timestamps; pending_o falls after the third push.
- Backpressure and full: evt_ready_i=0, 20 distinct bits rise → FIFO holds 16 and pending_o=1; after ready is raised all 20 arrive with no drops.
- Drop: bit 7 stays pending behind a full FIFO and pulses twice more → drop_cnt_o=2, overflow_o=1.
- Stop: stop_i at t=50, then bit 9 rises at t=55 → no record, frozen_o=1, timestamp holds, earlier pending records still drain.
- Reset mid-run: rst_i asserted with 5 queued records → evt_valid_o=0 and all counters are 0 asynchronously; with FAULT_REC_STICKY_EN, a second edge on bit 5 after its first push produces no record.
